// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iter
//  Purpose  : Iterative multiply/divide unit producing the HI/LO pair for
//             MULT, MULTU, DIV and DIVU. Radix-2 shift-add multiply and
//             restoring divide on operand magnitudes, one iteration per clock,
//             followed by a single sign-correction cycle. HI/LO are held here
//             and can be written directly (MTHI/MTLO) while idle.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             start, op, a, b   - launch request (op: 00 MULT, 01 MULTU,
//                                 10 DIV, 11 DIVU), sampled when not busy
//             mthi, mtlo, wdata - direct HI/LO writes, honoured when idle
//             busy, done        - operation in flight / result-written pulse
//             hi, lo            - architectural HI and LO registers
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic             r_is_div;
    logic             r_neg_lo;   // sign of product / quotient
    logic             r_neg_hi;   // sign of remainder (dividend sign)
    logic             r_div_zero;
    logic [WIDTH-1:0] r_m;        // multiplicand or divisor magnitude
    logic [WIDTH-1:0] r_acc;      // upper product half or partial remainder
    logic [WIDTH-1:0] r_q;        // multiplier shifting out / quotient shifting in

    // Operand conditioning at launch: signed ops (op[0]=0) work on magnitudes.
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // Multiply iteration: conditional add into the upper half, then shift the
    // whole {carry, acc, q} right by one.
    logic [WIDTH:0]   w_sum;
    assign w_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

    // Restoring divide iteration. The partial remainder is always below the
    // divisor, so a successful subtraction fits back into WIDTH bits.
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    assign w_shift = {r_acc, r_q[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_m});
    assign w_sub   = w_shift[WIDTH-1:0] - r_m;

    // Sign correction applied in the FIX cycle.
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;
    assign w_quot_fix = r_neg_lo ? -r_q : r_q;
    assign w_rem_fix  = r_neg_hi ? -r_acc : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_div_zero <= 1'b0;
            r_m        <= '0;
            r_acc      <= '0;
            r_q        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start) begin
                        r_state    <= S_CALC;
                        r_count    <= '0;
                        busy       <= 1'b1;
                        r_is_div   <= op[1];
                        r_acc      <= '0;
                        r_div_zero <= op[1] & (b == '0);
                        if (op[1]) begin
                            r_m      <= w_b_mag;
                            r_q      <= w_a_mag;
                            r_neg_lo <= w_a_neg ^ w_b_neg;
                            r_neg_hi <= w_a_neg;
                        end else begin
                            r_m      <= w_a_mag;
                            r_q      <= w_b_mag;
                            r_neg_lo <= w_a_neg ^ w_b_neg;
                            r_neg_hi <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    if (r_is_div) begin
                        r_acc <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= w_sum[WIDTH:1];
                        r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                    end
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        // Divide by zero leaves remainder = |a|, which the
                        // dividend-sign correction turns back into a.
                        hi <= w_rem_fix;
                        lo <= r_div_zero ? {WIDTH{1'b1}} : w_quot_fix;
                    end else begin
                        hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        lo <= w_prod_fix[WIDTH-1:0];
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_iter
//  Purpose  : Self-checking bench for mdu_iter. Expected HI/LO values come
//             from a behavioural arithmetic model pushed into a scoreboard
//             queue at launch and popped when done pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb_q[$];

    mdu_iter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Reference model: returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        case (o)
            2'b00: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                p  = 64'(sx * sy);
            end
            2'b01: p = {32'b0, x} * {32'b0, y};
            default: begin
                if (y == 32'd0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else begin
                    if (o == 2'b10) begin
                        sx = longint'($signed(x));
                        sy = longint'($signed(y));
                    end else begin
                        sx = longint'({32'b0, x});
                        sy = longint'({32'b0, y});
                    end
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch an operation at the current cycle and wait for its result.
    // poke>0 injects a DIVU start plus an MTHI at that busy cycle.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int poke);
        int n;
        logic [31:0] hi0, lo0;
        logic [63:0] e;
        n   = 0;
        hi0 = hi;
        lo0 = lo;
        sb_q.push_back(model(o, x, y));
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (poke > 0 && n == poke) begin
                start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
                mthi = 1'b1; wdata = 32'h0000_AAAA;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            if (poke > 0 && n == poke + 1) begin
                check({tag, "_hold_hi"}, {32'b0, hi}, {32'b0, hi0});
                check({tag, "_hold_lo"}, {32'b0, lo}, {32'b0, lo0});
            end
            tick();
        end
        start = 1'b0; mthi = 1'b0;
        check({tag, "_busy_cycles"}, 64'(n), 64'd33);
        check({tag, "_done"}, {63'b0, done}, 64'd1);
        e = sb_q.pop_front();
        check({tag, "_hi"}, {32'b0, hi}, {32'b0, e[63:32]});
        check({tag, "_lo"}, {32'b0, lo}, {32'b0, e[31:0]});
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        tick();
        tick();
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        rst = 1'b0;
        tick();

        // Direct writes while idle.
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234_5678;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        check("mt_both_hi", {32'b0, hi}, 64'h1234_5678);
        check("mt_both_lo", {32'b0, lo}, 64'h1234_5678);
        mtlo = 1'b1; wdata = 32'h0000_CAFE;
        tick();
        mtlo = 1'b0;
        check("mtlo_lo", {32'b0, lo}, 64'h0000_CAFE);
        check("mtlo_hi", {32'b0, hi}, 64'h1234_5678);

        // Directed arithmetic.
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        tick();
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7, 0);
        tick();
        run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        tick();
        run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        tick();
        run_op("divu_7_2",  2'b11, 32'd7, 32'd2, 0);
        tick();
        run_op("div_zero",  2'b10, 32'h1234_5678, 32'd0, 0);
        tick();
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        tick();
        run_op("divu_zero", 2'b11, 32'hDEAD_BEEF, 32'd0, 0);
        tick();
        run_op("div_negz",  2'b10, 32'hFFFF_FF00, 32'd0, 0);
        tick();

        // Interference while busy, then back-to-back starts in the done cycle.
        run_op("multu_poke", 2'b01, 32'd5, 32'd6, 5);
        run_op("b2b_div",    2'b10, 32'd100, 32'hFFFF_FFF9, 0);
        run_op("b2b_mult",   2'b00, $urandom, $urandom, 0);
        run_op("b2b_divu",   2'b11, $urandom, $urandom_range(1, 65535), 0);
        tick();

        // Reset mid-operation.
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_hi", {32'b0, hi}, 64'd0);
        check("abort_lo", {32'b0, lo}, 64'd0);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        check("abort_no_done", 64'(seen), 64'd0);
        mtlo = 1'b1; wdata = 32'h0000_0055;
        tick();
        mtlo = 1'b0;
        check("post_rst_mtlo", {32'b0, lo}, 64'h55);
        check("post_rst_hi", {32'b0, hi}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
